// File: rtl/sc_fifo_pkg.sv
// sc_fifo_pkg: shared constants and helpers for the single-clock FIFO.
//   fifo_depth(aw) : number of RAM words for an address width (1 << aw)
//   cnt_width(aw)  : width of pointers and the used-word count (aw + 1)
//   DEF_*          : default parameter values used by sc_fifo
package sc_fifo_pkg;

    localparam int DEF_DAT_WIDTH  = 8;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_AE_THRESH  = 1;
    // almost_full defaults to "two words short of full"
    localparam int DEF_AF_MARGIN  = 2;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic int cnt_width(input int addr_width);
        return addr_width + 1;
    endfunction

    localparam int DEF_AF_THRESH = fifo_depth(DEF_ADDR_WIDTH) - DEF_AF_MARGIN;

endpackage

// File: rtl/sc_fifo_ram.sv
// sc_fifo_ram: simple dual-port RAM used as the FIFO storage.
//   clk      : clock
//   wr_en    : write enable; wr_dat is stored at wr_addr
//   wr_addr  : write address
//   wr_dat   : write data
//   rd_en    : read enable; when low the read register holds (stall)
//   rd_clr   : synchronous clear of the read register only
//   rd_addr  : read address
//   rd_dat   : registered read data
// A read and write to the same address in one cycle returns the old word.
// The storage array itself has no reset.
module sc_fifo_ram
    import sc_fifo_pkg::*;
#(
    parameter int DAT_WIDTH  = DEF_DAT_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DAT_WIDTH-1:0]  wr_dat,
    input  logic                  rd_en,
    input  logic                  rd_clr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DAT_WIDTH-1:0]  rd_dat
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DAT_WIDTH-1:0] mem [DEPTH];
    logic [DAT_WIDTH-1:0] rd_dat_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Non-blocking read of mem gives old-data behaviour on an address collision.
    always_ff @(posedge clk) begin
        if (rd_clr) begin
            rd_dat_q <= '0;
        end else if (rd_en) begin
            rd_dat_q <= mem[rd_addr];
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/sc_fifo.sv
// sc_fifo: single-clock parametrised FIFO with optional show-ahead output.
//   clk          : clock
//   sclr         : synchronous active-high clear, beats every request
//   wr_dat/wr_req: write data / write request
//   wr_full      : no space (used == depth)
//   almost_full  : used >= AF_THRESH
//   rd_req       : read request (pop)
//   rd_dat       : read data
//   rd_empty     : nothing available at the read side
//   almost_empty : used <= AE_THRESH
//   used         : words stored (includes the show-ahead head word)
//   err_clr      : clears the sticky error flags
//   overflow     : sticky, write attempted while full
//   underflow    : sticky, read attempted while empty
// Build option: define SC_FIFO_ERR_FLAGS_EN to implement overflow/underflow;
// without it both are tied to 0 and err_clr is ignored.
// In show-ahead mode the RAM read register doubles as the head register, so
// a prefetch is simply a RAM read into it.
module sc_fifo
    import sc_fifo_pkg::*;
#(
    parameter int DAT_WIDTH  = DEF_DAT_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int SHOW_AHEAD = 0,
    parameter int AF_THRESH  = fifo_depth(ADDR_WIDTH) - DEF_AF_MARGIN,
    parameter int AE_THRESH  = DEF_AE_THRESH
) (
    input  logic                  clk,
    input  logic                  sclr,
    input  logic [DAT_WIDTH-1:0]  wr_dat,
    input  logic                  wr_req,
    output logic                  wr_full,
    output logic                  almost_full,
    input  logic                  rd_req,
    output logic [DAT_WIDTH-1:0]  rd_dat,
    output logic                  rd_empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   used,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CW = cnt_width(ADDR_WIDTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(fifo_depth(ADDR_WIDTH));
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] used_q, used_d;
    logic          head_valid_q, head_valid_d;

    logic wr_full_c;
    logic rd_empty_c;
    logic wr_acc;
    logic rd_acc;
    logic ram_rd_en;

    always_comb begin
        wr_full_c = (used_q == DEPTH_C);
        if (SHOW_AHEAD != 0) begin
            rd_empty_c = ~head_valid_q;
        end else begin
            rd_empty_c = (used_q == '0);
        end

        wr_acc = wr_req & ~wr_full_c & ~sclr;
        rd_acc = rd_req & ~rd_empty_c & ~sclr;

        // Show-ahead: refill the head whenever it is empty or being popped
        // and the RAM still holds unread words (pointers differ).
        if (SHOW_AHEAD != 0) begin
            ram_rd_en = (~head_valid_q | rd_acc) & (wr_ptr_q != rd_ptr_q) & ~sclr;
        end else begin
            ram_rd_en = rd_acc;
        end

        head_valid_d = head_valid_q;
        if (SHOW_AHEAD != 0) begin
            if (ram_rd_en) begin
                head_valid_d = 1'b1;
            end else if (rd_acc) begin
                head_valid_d = 1'b0;
            end
        end

        wr_ptr_d = wr_acc    ? wr_ptr_q + ONE_C : wr_ptr_q;
        rd_ptr_d = ram_rd_en ? rd_ptr_q + ONE_C : rd_ptr_q;

        case ({wr_acc, rd_acc})
            2'b10:   used_d = used_q + ONE_C;
            2'b01:   used_d = used_q - ONE_C;
            default: used_d = used_q;
        endcase

        if (sclr) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            used_d       = '0;
            head_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_q     <= wr_ptr_d;
        rd_ptr_q     <= rd_ptr_d;
        used_q       <= used_d;
        head_valid_q <= head_valid_d;
    end

    sc_fifo_ram #(
        .DAT_WIDTH  (DAT_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_dat  (wr_dat),
        .rd_en   (ram_rd_en),
        .rd_clr  (sclr),
        .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_dat  (rd_dat)
    );

    assign wr_full      = wr_full_c;
    assign rd_empty     = rd_empty_c;
    assign used         = used_q;
    assign almost_full  = (used_q >= AF_C);
    assign almost_empty = (used_q <= AE_C);

`ifdef SC_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // A new violation wins over err_clr in the same cycle; sclr wins over all.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_req & wr_full_c) begin
            overflow_d = 1'b1;
        end
        if (rd_req & rd_empty_c) begin
            underflow_d = 1'b1;
        end
        if (sclr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        overflow_q  <= overflow_d;
        underflow_q <= underflow_d;
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: doc/sc_fifo.md
# sc_fifo

Single-clock, parametrised FIFO: the same-clock successor of the team's dual-clock FIFO, for datapaths where producer and consumer share one clock. It adds:
- a show-ahead (first-word-fall-through) mode;
- programmable almost-full and almost-empty flags;
- a unified used-word count;
- optional sticky overflow and underflow error flags.

It sits between pipeline stages and packet buffers, replacing vendor scfifo instances.

## Interface
- DAT_WIDTH, 8: data word width.
- ADDR_WIDTH, 8: RAM address width. Depth is 2^ADDR_WIDTH words. Internal pointers are ADDR_WIDTH+1 bits.
- SHOW_AHEAD, 0: 0 = normal read (data follows rd_req); 1 = first-word-fall-through.
- AF_THRESH, 2^ADDR_WIDTH-2: almost_full asserts when used >= AF_THRESH.
- AE_THRESH, 1: almost_empty asserts when used <= AE_THRESH.

Ports:
- clk  in  1  the single clock.
- sclr  in  1  reset. Synchronous, active-high, single clock domain. Takes priority over every request in the same cycle.
- wr_dat  in  DAT_WIDTH  write data.
- wr_req  in  1  write request.
- wr_full  out  1  no space.
- almost_full  out  1  used >= AF_THRESH.
- rd_req  in  1  read request (pop).
- rd_dat  out  DAT_WIDTH  read data.
- rd_empty  out  1  no data available at the read side.
- almost_empty  out  1  used <= AE_THRESH.
- used  out  ADDR_WIDTH+1  words currently stored.
- err_clr  in  1  clears the sticky error flags.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

## Operation
- Accepted write: wr_acc = wr_req & !wr_full & !sclr. Accepted read: rd_acc = rd_req & !rd_empty & !sclr.
- Rejected requests change no state, except the error flags.
- used(n+1) = used(n) + wr_acc - rd_acc. The result never wraps.
- wr_full = (used == 2^ADDR_WIDTH), decoded from the registered count.
- Pointer wrap: the low ADDR_WIDTH bits address the RAM. The MSB distinguishes full from empty, and wraps modulo 2^(ADDR_WIDTH+1).
- Simultaneous write and read:
  - While full: the read is accepted and the write is rejected; used decrements.
  - While empty: the write is accepted and the read is rejected.
  - Otherwise both are accepted; used is unchanged.
- Normal mode (SHOW_AHEAD=0):
  - rd_empty = (used == 0).
  - rd_dat updates on the clock edge one cycle after rd_acc, and holds otherwise.
- Show-ahead mode (SHOW_AHEAD=1):
  - A 1-word output register holds the head word. rd_empty = !head_valid.
  - The block prefetches from RAM whenever head_valid is clear, or rd_acc, and the RAM holds unread words.
  - rd_dat is valid whenever !rd_empty. After rd_acc the next word is presented without a bubble if it is already in RAM.
  - used counts all words, including the head register.
- Reset: sclr clears pointers, used, head_valid, rd_dat and the error flags to 0. The contents are discarded. Resetting mid-burst is legal.
- Reset values of the outputs: wr_full=0, almost_full=0 (AF_THRESH>0), rd_empty=1, almost_empty=1, used=0, rd_dat=0, overflow=0, underflow=0.

## Timing
- Write to used, wr_full and almost flags: 1 cycle (registered count).
- Write to !rd_empty:
  - Normal mode: 1 cycle.
  - Show-ahead mode: 2 cycles. The prefetch is a registered RAM read.
- Normal-mode read latency: rd_dat is valid 1 cycle after rd_acc.
- No read-during-write address hazard exists: a read never targets the slot being written in the same cycle.
- Sustained throughput: 1 write and 1 read per clock in both modes.
- Error flags set on the edge following the offending request, and stay set until err_clr or sclr. If err_clr and a new violation occur in the same cycle, set wins.

## Configuration
- SC_FIFO_ERR_FLAGS_EN defined: overflow and underflow are implemented as sticky registers, and err_clr is honoured.
- Not defined: overflow and underflow are tied to 0, err_clr is ignored, and no error logic is synthesised. The port list is unchanged.

## Structure
- Package sc_fifo_pkg holds:
  - the depth constant function (1 << ADDR_WIDTH);
  - the default threshold constants;
  - the used-count width constant.
- Sub-module sc_fifo_ram: simple dual-port RAM with a registered read port, old-data read-during-write behaviour, and a read-enable stall. It has no reset on its contents.
- Pointer, count, flag and show-ahead logic live in the top module.

## Test plan
- Fill to full, then overflow: ADDR_WIDTH=2; write 0x01..0x05 back-to-back.
  - Required: used reaches 4, wr_full=1 after the 4th write, and 0x05 is dropped.
  - Required: overflow=1 with the macro defined, 0 without.
- Drain and underflow: from a full FIFO, read 5 times.
  - Required: normal mode returns 0x01..0x04 in order, each 1 cycle after its rd_req.
  - Required: rd_empty=1 and used=0 after the 4th read; underflow=1 with the macro defined.
- Show-ahead latency: SHOW_AHEAD=1; write 0xA5 into an empty FIFO.
  - Required: rd_empty falls 2 cycles later, with rd_dat=0xA5 and no rd_req needed.
  - Required: a subsequent rd_req gives rd_empty=1 on the next cycle.
- Simultaneous full read and write: ADDR_WIDTH=2, FIFO full.
  - Required: wr_req and rd_req together give one pop and no push, and used goes 4 to 3.
  - Required: with used=2, wr_req and rd_req together leave used=2.
- Pointer wrap and throughput: ADDR_WIDTH=3; run 1000 cycles of random, concurrent, legal wr_req/rd_req.
  - Required: the data order matches a reference queue, used matches the queue size, and almost_full/almost_empty match the thresholds every cycle.
- Reset mid-operation: assert sclr with used=5 while wr_req and rd_req are high.
  - Required: the next cycle shows used=0, rd_empty=1, rd_dat=0 and error flags 0.
  - Required: the first write after reset is read back first.
